// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction fetch unit for the single-issue RISC-V core.
//
// Issues one word fetch at a time over a req/gnt/rvalid memory interface.
// The returned word is held on a valid/ready output until it is consumed.
// On that handshake the next PC is taken from pc_sel_i: 00/11 -> PC+4,
// 01 -> branch_target_i, 10 -> jump_target_i.
//
// Optional feature macro: RISCV_FETCH_MISALIGN_TRAP_EN
//   undefined : bits [1:0] of the selected next PC are silently cleared
//   defined   : a misaligned next PC raises fetch_misalign_o and parks the
//               unit in HALT (the faulting target stays on imem_addr_o);
//               only reset leaves HALT
//
// Ports:
//   clk, reset                 core clock, synchronous active-high reset
//   imem_req_o / imem_addr_o   fetch request (held until granted) and address
//   imem_gnt_i                 memory accepts the request
//   imem_rvalid_i/imem_rdata_i returned instruction word
//   instr_valid_o/instr_ready_i output handshake
//   instr_o, instr_op_o, instr_funct3_o, instr_funct7_o  word and field slices
//   instr_pc_o, pc4_o          PC of instr_o and PC+4
//   pc_sel_i, branch_target_i, jump_target_i  next-PC selection
//   fetch_count_o              instructions delivered (wraps)
//   fetch_misalign_o           misaligned-target trap (feature build only)
//
// state | meaning
// ------+-------------------------------------------------------
// REQ   | request asserted at pc, waiting for gnt
// WAIT  | request granted, waiting for rvalid
// VALID | instruction presented, waiting for ready
// HALT  | misaligned target trapped (feature build only)

module riscv_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [6:0]      instr_op_o,
    output logic [2:0]      instr_funct3_o,
    output logic [6:0]      instr_funct7_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [XLEN-1:0] pc4_o,
    input  logic [1:0]      pc_sel_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [XLEN-1:0] jump_target_i,
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
    output logic            fetch_misalign_o,
`endif
    output logic [31:0]     fetch_count_o
);

`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} state_t;
`endif

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] next_pc;

    assign imem_addr_o    = pc;
    assign pc4_o          = instr_pc_o + XLEN'(4);
    assign instr_op_o     = instr_o[6:0];
    assign instr_funct3_o = instr_o[14:12];
    assign instr_funct7_o = instr_o[31:25];

    always_comb begin
        sel_pc = pc4_o;
        case (pc_sel_i)
            2'b01:   sel_pc = branch_target_i;
            2'b10:   sel_pc = jump_target_i;
            default: sel_pc = pc4_o;
        endcase
    end

`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
    // Keep the raw target so a fault leaves the offending address visible.
    assign next_pc = sel_pc;
`else
    assign next_pc = sel_pc & ~XLEN'(3);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_REQ;
            pc            <= RESET_PC;
            imem_req_o    <= 1'b0;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            instr_pc_o    <= '0;
            fetch_count_o <= '0;
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
            fetch_misalign_o <= 1'b0;
`endif
        end else begin
            case (state)
                S_REQ: begin
                    // req is registered, so the first post-reset cycle only
                    // raises it; a gnt is honoured only while req is high.
                    imem_req_o <= 1'b1;
                    if (imem_req_o && imem_gnt_i) begin
                        imem_req_o <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        instr_o       <= imem_rdata_i;
                        instr_pc_o    <= pc;
                        instr_valid_o <= 1'b1;
                        state         <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (instr_ready_i) begin
                        instr_valid_o <= 1'b0;
                        fetch_count_o <= fetch_count_o + 32'd1;
                        pc            <= next_pc;
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
                        if (next_pc[1:0] != 2'b00) begin
                            fetch_misalign_o <= 1'b1;
                            state            <= S_HALT;
                        end else begin
                            imem_req_o <= 1'b1;
                            state      <= S_REQ;
                        end
`else
                        imem_req_o <= 1'b1;
                        state      <= S_REQ;
`endif
                    end
                end
                default: begin
                    // HALT: idle until reset.
                    imem_req_o    <= 1'b0;
                    instr_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
